pkt_tx: RTL and testbench

PKT_TX -- requirements
Module: pkt_tx

---
 rtl/pkt_tx.sv | 100 ++++++++++
 tb/tb_pkt_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx.sv
// pkt_tx: 2-slot packet FIFO serialised into a 16-bit ready/valid word stream; define TX_CHECKSUM_EN to append an XOR checksum word
module pkt_tx #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        load,
  input  logic [15:0] sourceID,
  input  logic [15:0] destinationID,
  input  logic [15:0] clusterID,
  input  logic [15:0] batteryStat,
  input  logic [15:0] Value,
  input  logic        forAggregation,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        sent,
  output logic        full,
  output logic [7:0]  drop_cnt
);
`ifdef TX_CHECKSUM_EN
  localparam int NW = 7;
`else
  localparam int NW = 6;
`endif
  localparam logic [2:0] LAST = 3'(NW - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t      state;
  logic [80:0] mem [2];
  logic [80:0] head;
  logic        wp, rp;
  logic [1:0]  cnt;
  logic [2:0]  idx;
  logic [15:0] words [NW];
  logic        pop, push, drop;
  assign head = mem[rp];
  assign full = cnt == 2'd2;
  assign pop  = state == SEND && tx_valid && tx_ready && tx_last;
  assign push = load && (!full || pop);
  assign drop = load && full && !pop;
  always_comb begin
    words[0] = {SYNC, 7'b0, head[80]};
    words[1] = head[79:64];
    words[2] = head[63:48];
    words[3] = head[47:32];
    words[4] = head[31:16];
    words[5] = head[15:0];
`ifdef TX_CHECKSUM_EN
    words[6] = words[0] ^ words[1] ^ words[2] ^ words[3] ^ words[4] ^ words[5];
`endif
  end
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state    <= IDLE;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= 2'd0;
      idx      <= 3'd0;
      tx_data  <= 16'd0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      sent     <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (push) begin
        mem[wp] <= {forAggregation, sourceID, destinationID, clusterID, batteryStat, Value};
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt  <= cnt + 2'(push) - 2'(pop);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      sent <= 1'b0;
      case (state)
        IDLE: if (cnt != 2'd0) begin
          state <= SEND;
          idx   <= 3'd0;
        end
        SEND: if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_data  <= words[idx];
          tx_last  <= idx == LAST;
        end else if (tx_ready) begin
          if (tx_last) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            sent     <= 1'b1;
            state    <= GAP;
          end else begin
            idx     <= idx + 3'd1;
            tx_data <= words[idx + 3'd1];
            tx_last <= (idx + 3'd1) == LAST;
          end
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_tx.sv
// tb_pkt_tx: randomized scoreboard bench for pkt_tx with a frame-level reference model
module tb_pkt_tx;
`ifdef TX_CHECKSUM_EN
  localparam int NW = 7;
`else
  localparam int NW = 6;
`endif
  logic        clock = 0, nrst = 0, load = 0, forAggregation = 0, tx_ready = 0;
  logic [15:0] sourceID = 0, destinationID = 0, clusterID = 0, batteryStat = 0, Value = 0;
  logic [15:0] tx_data;
  logic        tx_valid, tx_last, sent, full;
  logic [7:0]  drop_cnt;
  int          checks = 0, errors = 0, nsent = 0, occ = 0, pos = 0, dexp = 0;
  bit          armed = 0, sexp = 0, stall_p = 0, last_p = 0, rst_p = 0;
  logic [16:0] hold = 0;
  logic [16:0] expw[$];

  always #5 clock = ~clock;

  pkt_tx dut (
    .clock(clock), .nrst(nrst), .load(load),
    .sourceID(sourceID), .destinationID(destinationID), .clusterID(clusterID),
    .batteryStat(batteryStat), .Value(Value), .forAggregation(forAggregation),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .sent(sent), .full(full), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    logic [15:0] w [7];
    w[0] = {8'hA5, 7'b0, forAggregation};
    w[1] = sourceID;
    w[2] = destinationID;
    w[3] = clusterID;
    w[4] = batteryStat;
    w[5] = Value;
    w[6] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5];
    for (int i = 0; i < NW; i++) expw.push_back({i == NW - 1, w[i]});
  endtask

  // reference model: frame occupancy, drops and sent pulses, checked against state left by the previous edge
  always @(negedge clock) if (armed) begin
    bit fin;
    chk("full", 32'(full), 32'(occ == 2));
    chk("drop_cnt", 32'(drop_cnt), 32'(dexp));
    chk("sent", 32'(sent), 32'(sexp));
    if (!nrst) begin
      occ = 0; pos = 0; dexp = 0; sexp = 0;
    end else begin
      fin = 0;
      if (tx_valid && tx_ready && occ > 0) begin
        pos++;
        if (pos == NW) begin pos = 0; occ--; fin = 1; end
      end
      sexp = fin;
      if (load) begin
        if (occ < 2) begin push_frame(); occ++; end
        else if (dexp != 255) dexp++;
      end
    end
  end

  // monitor: pops expected words on each transfer and checks handshake rules
  always @(negedge clock) if (armed) begin
    if (stall_p && !rst_p) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_word", 32'({tx_last, tx_data}), 32'(hold));
    end
    if (last_p && !rst_p) chk("gap", 32'(tx_valid), 32'd0);
    if (sent) nsent++;
    if (!nrst) expw.delete();
    else if (tx_valid && tx_ready) begin
      if (expw.size() == 0) begin
        checks++; errors++;
        $display("FAIL word actual=%0h required=none at %0t", {tx_last, tx_data}, $time);
      end else chk("word", 32'({tx_last, tx_data}), 32'(expw.pop_front()));
    end
    stall_p = tx_valid && !tx_ready;
    hold    = {tx_last, tx_data};
    last_p  = nrst && tx_valid && tx_ready && tx_last;
    rst_p   = !nrst;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_fields();
    sourceID = 16'($urandom); destinationID = 16'($urandom); clusterID = 16'($urandom);
    batteryStat = 16'($urandom); Value = 16'($urandom); forAggregation = 1'($urandom);
  endtask

  task automatic load_one();
    rand_fields();
    load = 1;
    step();
    load = 0;
  endtask

  task automatic do_reset();
    load = 0; nrst = 0;
    step(); step();
    nrst = 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    tx_ready = 1;
    while ((occ != 0 || tx_valid) && n < 300) begin step(); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain actual=timeout required=empty at %0t", $time);
    end
    repeat (3) step();
  endtask

  initial begin
    int s0, n, cnt;
    bit found;
    step(); step();
    armed = 1;
    @(negedge clock);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_last", 32'(tx_last), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_sent", 32'(sent), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    step();
    nrst = 1;
    // single known frame, tx_ready held high
    tx_ready = 1;
    sourceID = 16'd15; destinationID = 16'd3; clusterID = 16'd2;
    batteryStat = 16'h4000; Value = 16'h0680; forAggregation = 0;
    s0 = nsent;
    load = 1;
    step();
    load = 0;
    @(negedge clock); chk("lat_e0", 32'(tx_valid), 0);
    @(negedge clock); chk("lat_e1", 32'(tx_valid), 0);
    @(negedge clock); chk("lat_e2", 32'(tx_valid), 1);
    chk("lat_w0", 32'(tx_data), 32'h0000A500);
    drain();
    chk("sent_once", 32'(nsent - s0), 1);
    // backpressure pattern 1,0,0,1
    s0 = nsent;
    load_one();
    for (int k = 0; k < 40; k++) begin
      tx_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    drain();
    chk("bp_sent", 32'(nsent - s0), 1);
    // overflow: three back-to-back loads with the sink stalled
    do_reset();
    tx_ready = 0;
    s0 = nsent;
    rand_fields(); load = 1; step();
    rand_fields(); step();
    rand_fields();
    @(negedge clock); chk("ovf_full", 32'(full), 1);
    step();
    load = 0;
    @(negedge clock); chk("ovf_drop", 32'(drop_cnt), 1);
    drain();
    chk("ovf_sent", 32'(nsent - s0), 2);
    // load coinciding with the final-word transfer while full
    do_reset();
    tx_ready = 0;
    s0 = nsent;
    load_one(); load_one();
    @(negedge clock); chk("swap_full0", 32'(full), 1);
    step();
    tx_ready = 1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx_valid && tx_last && tx_ready) begin
        rand_fields(); load = 1; step(); load = 0; found = 1;
        break;
      end
      step();
    end
    chk("swap_seen", 32'(found), 1);
    @(negedge clock);
    chk("swap_full1", 32'(full), 1);
    chk("swap_drop", 32'(drop_cnt), 0);
    drain();
    chk("swap_sent", 32'(nsent - s0), 3);
    // reset after W2 transfers
    do_reset();
    tx_ready = 1;
    load_one(); load_one();
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (tx_valid && tx_ready) begin
        n++;
        if (n == 3) break;
      end
      step();
    end
    chk("w2_reached", 32'(n), 3);
    step();
    s0 = nsent;
    nrst = 0; rand_fields(); load = 1;
    step();
    nrst = 1; load = 0;
    @(negedge clock);
    chk("abort_valid", 32'(tx_valid), 0);
    chk("abort_full", 32'(full), 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_valid) cnt++;
    end
    chk("no_resend", 32'(cnt), 0);
    chk("abort_sent", 32'(nsent - s0), 0);
    // saturation of drop_cnt
    do_reset();
    tx_ready = 0;
    s0 = nsent;
    load = 1;
    repeat (302) begin rand_fields(); step(); end
    load = 0;
    @(negedge clock);
    chk("sat_drop", 32'(drop_cnt), 255);
    chk("sat_full", 32'(full), 1);
    drain();
    chk("sat_sent", 32'(nsent - s0), 2);
    // random traffic
    do_reset();
    repeat (600) begin
      rand_fields();
      load = ($urandom % 4) == 0;
      tx_ready = ($urandom % 3) != 0;
      step();
    end
    load = 0;
    drain();
    chk("final_empty", 32'(expw.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
